// File: rtl/key_pkg.sv
//==============================================================================
// Module      : key_pkg
// Description : Shared widths, FSM state type and key byte-select helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package key_pkg;

  localparam int KEY_BYTES = 8;
  localparam int BYTE_W    = 8;
  localparam int KEY_W     = KEY_BYTES * BYTE_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    RESULT = 2'd2,
    LOCK   = 2'd3
  } state_t;

  // Keys are declared [0:KEY_W-1]; byte i occupies bits [8i:8i+7], bit 8i is its MSB.
  function automatic logic [BYTE_W-1:0] key_byte(input logic [0:KEY_W-1] key,
                                                 input int unsigned      idx);
    return key[BYTE_W*idx +: BYTE_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_verifier_if.sv
//==============================================================================
// Module      : key_verifier_if
// Description : Key inputs, candidate byte stream and status outputs of key_verifier.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface key_verifier_if #(
  parameter int NUM_BYTES = 8,
  parameter int MAX_FAILS = 3
);

  localparam int c_FC_W = $clog2(MAX_FAILS + 1);

  logic [0:8*NUM_BYTES-1] master_key;
  logic [0:8*NUM_BYTES-1] baby_key;
  logic                   start;
  logic                   abort;
  logic                   in_valid;
  logic [7:0]             in_byte;
  logic                   in_ready;
  logic                   busy;
  logic                   done;
  logic                   match;
  logic                   locked;
  logic [c_FC_W-1:0]      fail_count;

  modport master (
    output master_key, baby_key, start, abort, in_valid, in_byte,
    input  in_ready, busy, done, match, locked, fail_count
  );

  modport slave (
    input  master_key, baby_key, start, abort, in_valid, in_byte,
    output in_ready, busy, done, match, locked, fail_count
  );

endinterface

`default_nettype wire

// File: rtl/key_byte_max.sv
//==============================================================================
// Module      : key_byte_max
// Description : Combinational unsigned maximum of two bytes.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module key_byte_max
  import key_pkg::*;
(
  input  logic [BYTE_W-1:0] i_a,
  input  logic [BYTE_W-1:0] i_b,
  output logic [BYTE_W-1:0] o_max
);

  assign o_max = (i_a > i_b) ? i_a : i_b;

endmodule

`default_nettype wire

// File: rtl/key_verifier.sv
//==============================================================================
// Module      : key_verifier
// Description : Byte-serial check of a candidate key against max(master, baby),
//               with consecutive-failure counting and timed lockout.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module key_verifier
  import key_pkg::*;
#(
  parameter int NUM_BYTES      = 8,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  key_verifier_if.slave  bus
);

  localparam int c_IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int c_FC_W   = $clog2(MAX_FAILS + 1);
  localparam int c_LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(NUM_BYTES - 1);
  localparam logic [c_FC_W-1:0]   c_FC_MAX    = c_FC_W'(MAX_FAILS);
  localparam logic [c_LOCK_W-1:0] c_LOCK_INIT = c_LOCK_W'(LOCKOUT_CYCLES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [BYTE_W-1:0]   w_combined [NUM_BYTES];
  logic [BYTE_W-1:0]   r_expected [NUM_BYTES];
  logic [c_IDX_W-1:0]  r_idx;
  logic                r_mismatch;
  logic                r_match;
  logic [c_FC_W-1:0]   r_fail_count;
  logic [c_FC_W-1:0]   w_fail_inc;
  logic [c_LOCK_W-1:0] r_lock_cnt;
  logic                w_hs;
  logic                w_byte_diff;
  logic                w_last;

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte_max
    key_byte_max u_byte_max (
      .i_a   (bus.master_key[BYTE_W*gi +: BYTE_W]),
      .i_b   (bus.baby_key[BYTE_W*gi +: BYTE_W]),
      .o_max (w_combined[gi])
    );
  end

  assign w_hs        = (r_state == RECV) && bus.in_valid;
  assign w_byte_diff = (bus.in_byte != r_expected[r_idx]);
  assign w_last      = (r_idx == c_IDX_LAST);
  assign w_fail_inc  = (r_fail_count == c_FC_MAX) ? r_fail_count
                                                  : r_fail_count + c_FC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next = RECV;
      end
      RECV: begin
        // abort wins over a handshake arriving in the same cycle
        if (bus.abort)          w_next = IDLE;
        else if (w_hs && w_last) w_next = RESULT;
      end
      RESULT: begin
        if (r_mismatch && (w_fail_inc == c_FC_MAX)) w_next = LOCK;
        else                                        w_next = IDLE;
      end
      LOCK: begin
        if (r_lock_cnt == '0) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.locked   = 1'b0;
    case (r_state)
      RECV: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
      end
      RESULT: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      LOCK: begin
        bus.busy   = 1'b1;
        bus.locked = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_mismatch   <= 1'b0;
      r_match      <= 1'b0;
      r_fail_count <= '0;
      r_lock_cnt   <= '0;
      for (int i = 0; i < NUM_BYTES; i++) r_expected[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < NUM_BYTES; i++) r_expected[i] <= w_combined[i];
            r_idx      <= '0;
            r_mismatch <= 1'b0;
            r_match    <= 1'b0;
          end
        end
        RECV: begin
          if (bus.abort) begin
            r_idx <= '0;
          end else if (w_hs) begin
            r_mismatch <= r_mismatch | w_byte_diff;
            r_idx      <= w_last ? '0 : r_idx + c_IDX_W'(1);
            // match is registered here so it is already valid in the done cycle
            if (w_last) r_match <= ~(r_mismatch | w_byte_diff);
          end
        end
        RESULT: begin
          r_fail_count <= r_mismatch ? w_fail_inc : '0;
          r_lock_cnt   <= c_LOCK_INIT;
        end
        LOCK: begin
          if (r_lock_cnt == '0) r_fail_count <= '0;
          else                  r_lock_cnt   <= r_lock_cnt - c_LOCK_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.match      = r_match;
  assign bus.fail_count = r_fail_count;

endmodule

`default_nettype wire

// File: tb/tb_key_verifier.sv
//==============================================================================
// Module      : tb_key_verifier
// Description : Scoreboard bench for key_verifier with a behavioural key model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_key_verifier;
  import key_pkg::*;

  localparam int MAX_F  = 3;
  localparam int LOCK_C = 1024;

  typedef struct {
    bit ok;
    int fc;
    bit lock;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   model_fc;
  exp_t exp_q[$];
  exp_t e_pend;
  bit   pend;

  key_verifier_if #(.NUM_BYTES(KEY_BYTES), .MAX_FAILS(MAX_F)) kv ();

  key_verifier #(
    .NUM_BYTES      (KEY_BYTES),
    .MAX_FAILS      (MAX_F),
    .LOCKOUT_CYCLES (LOCK_C)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Unlock key: each byte is the larger of the two key bytes.
  function automatic logic [0:63] model_key(input logic [0:63] m, input logic [0:63] b);
    logic [0:63] k;
    for (int i = 0; i < KEY_BYTES; i++) begin
      logic [7:0] x;
      logic [7:0] y;
      x = key_byte(m, i);
      y = key_byte(b, i);
      k[8*i +: 8] = (x > y) ? x : y;
    end
    return k;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else if (kv.done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        e_pend = exp_q.pop_front();
        check("match", kv.match, e_pend.ok);
        check("done_busy", kv.busy, 1'b1);
        pend = 1'b1;
      end
    end else if (pend) begin
      check("fail_count", kv.fail_count, e_pend.fc);
      check("locked", kv.locked, e_pend.lock);
      pend = 1'b0;
    end
  end

  task automatic post_attempt(input bit lock);
    @(posedge clk); #1;
    if (lock) begin
      int cnt = 0;
      kv.start = 1'b1; kv.abort = 1'b1; kv.in_valid = 1'b1;
      while (kv.locked && cnt < 2000) begin
        @(posedge clk); #1;
        cnt++;
      end
      kv.start = 1'b0; kv.abort = 1'b0; kv.in_valid = 1'b0;
      check("lock_cycles", cnt, LOCK_C);
      check("post_lock_fc", kv.fail_count, 0);
      model_fc = 0;
    end
    check("idle_busy", kv.busy, 1'b0);
  endtask

  // abort_at < 0: full attempt; otherwise abort together with byte abort_at.
  task automatic attempt(input logic [0:63] m, input logic [0:63] b, input logic [0:63] cand,
                         input int abort_at, input bit swap_key);
    logic [0:63] exp_key;
    bit ok;
    bit lock;
    exp_key = model_key(m, b);
    kv.master_key = m;
    kv.baby_key   = b;
    kv.start = 1'b1;
    @(posedge clk); #1;
    kv.start = 1'b0;
    check("start_ready", kv.in_ready, 1'b1);
    if (swap_key) begin
      kv.master_key = {$urandom, $urandom};
      kv.baby_key   = ~b;
    end
    for (int i = 0; i < KEY_BYTES; i++) begin
      if (i == abort_at) begin
        kv.abort = 1'b1; kv.in_valid = 1'b1; kv.in_byte = key_byte(cand, i);
        @(posedge clk); #1;
        kv.abort = 1'b0; kv.in_valid = 1'b0;
        check("abort_ready", kv.in_ready, 1'b0);
        check("abort_busy", kv.busy, 1'b0);
        check("abort_fc", kv.fail_count, model_fc);
        check("abort_match", kv.match, 1'b0);
        return;
      end
      kv.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        kv.in_byte = 8'($urandom);
        @(posedge clk); #1;
      end
      kv.in_valid = 1'b1;
      kv.in_byte  = key_byte(cand, i);
      if (i == KEY_BYTES - 1) begin
        ok = (cand == exp_key);
        if (ok) model_fc = 0;
        else if (model_fc < MAX_F) model_fc++;
        lock = (model_fc == MAX_F);
        exp_q.push_back('{ok, model_fc, lock});
      end
      @(posedge clk); #1;
    end
    kv.in_valid = 1'b0;
    check("done_latency", kv.done, 1'b1);
    post_attempt(lock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, kv.in_ready, 1'b0);
    check({tag, "_busy"}, kv.busy, 1'b0);
    check({tag, "_done"}, kv.done, 1'b0);
    check({tag, "_match"}, kv.match, 1'b0);
    check({tag, "_locked"}, kv.locked, 1'b0);
    check({tag, "_fail_count"}, kv.fail_count, 0);
  endtask

  initial begin
    logic [0:63] m;
    logic [0:63] b;
    logic [0:63] good;
    logic [0:63] bad;
    n_tests = 0; n_fail = 0; model_fc = 0; pend = 1'b0;
    rst_n = 1'b0;
    kv.master_key = '0; kv.baby_key = '0; kv.start = 1'b0; kv.abort = 1'b0;
    kv.in_valid = 1'b0; kv.in_byte = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    m    = 64'h0011223344556677;
    b    = 64'h7766554433221100;
    good = 64'h7766554444556677;
    bad  = 64'h7766554444556676;

    attempt(m, b, good, -1, 1'b0);
    attempt(m, b, bad,  -1, 1'b0);
    attempt(m, b, bad,  -1, 1'b0);
    attempt(m, b, good, -1, 1'b0);
    bad = 64'h0066554444556677;
    repeat (3) attempt(m, b, bad, -1, 1'b0);

    attempt(m, b, bad, -1, 1'b0);
    attempt(m, b, good, 3, 1'b0);
    attempt(m, b, good, -1, 1'b0);
    attempt(m, b, good, -1, 1'b1);

    for (int t = 0; t < 16; t++) begin
      logic [0:63] c;
      m = {$urandom, $urandom};
      b = {$urandom, $urandom};
      c = model_key(m, b);
      if ($urandom_range(0, 1) == 1) begin
        int p;
        p = $urandom_range(0, KEY_BYTES - 1);
        c[8*p +: 8] = c[8*p +: 8] ^ 8'($urandom_range(1, 255));
      end
      attempt(m, b, c, -1, t[2]);
    end

    attempt(m, b, ~model_key(m, b), -1, 1'b0);
    kv.master_key = m; kv.baby_key = b;
    kv.start = 1'b1;
    @(posedge clk); #1;
    kv.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      kv.in_valid = 1'b1;
      kv.in_byte  = key_byte(model_key(m, b), i);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    kv.in_valid = 1'b0;
    check_all_zero("midreset");
    model_fc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    attempt(m, b, model_key(m, b), -1, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
